lcd_write_sched: RTL and testbench
==================================

Name: lcd_write_sched

Overview:
Shared-access scheduler for the 8-bit HD44780-style LCD bus (RS/EN/DATA). It runs the power-on wait, then arbitrates byte writes from two requesters with round-robin priority. Requester 0 is the row-refresh engine; requester 1 is the command/status source. For each granted byte it drives RS/DATA, generates the timed EN pulse, and waits the controller execution time before accepting the next byte. It sits between the requesters and the LCD pins in the top level.

Parameters:
POR_CYC, 750000, power-on wait after reset in clk cycles (15 ms at 50 MHz)
EN_SETUP_CYC, 2, cycles RS/DATA are stable before EN rises
EN_HIGH_CYC, 25, EN high width in cycles
EN_HOLD_CYC, 2, cycles RS/DATA are held after EN falls before the execution wait
EXEC_CYC, 2500, execution wait for normal commands/data (50 us)
LONG_EXEC_CYC, 82000, execution wait for clear/home commands (1.64 ms)
CNT_W, 20, timer width; must hold max(all *_CYC)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 write request (level)
rs0  in  1  requester 0 RS value (0 = command, 1 = data)
data0  in  8  requester 0 byte
gnt0  out  1  one-cycle pulse: requester 0 byte captured
done0  out  1  one-cycle pulse: requester 0 byte fully executed
req1, rs1, data1, gnt1, done1  same as above for requester 1
busy  out  1  high whenever the scheduler is not in IDLE
RS  out  1  LCD register select
EN  out  1  LCD enable strobe
DATA  out  8  LCD data bus

Behaviour:
- Reset: clk and reset_n as listed above; reset is asynchronous and active-low. While reset_n=0: RS=0, EN=0, DATA=0x00, gnt*=0, done*=0, busy=1, state=INIT_WAIT, timer loaded with POR_CYC-1, RR pointer favours requester 0.
- All outputs are registered. EN is never driven combinationally.
- INIT_WAIT: lasts POR_CYC cycles, then goes to IDLE. Requests are ignored (not lost; requesters simply keep req high).
- IDLE: busy=0. If any reqN is high at an edge, capture that requester's rs/data into RS/DATA, pulse gntN high for the next cycle, load the timer, and go to SETUP.
  - Arbitration when both requests are high: grant the requester the pointer favours.
  - After every grant, the pointer moves to favour the other requester.
- SETUP: EN_SETUP_CYC cycles, EN=0, then PULSE.
- PULSE: EN=1 for exactly EN_HIGH_CYC cycles, then HOLD.
- HOLD: EN=0 for EN_HOLD_CYC cycles, then EXEC.
- EXEC: wait LONG_EXEC_CYC if the captured RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise wait EXEC_CYC.
  - On the final EXEC cycle, pulse doneN for the owner for one cycle (coincident with the transition to IDLE).
- Latency: from the gntN cycle to the doneN cycle is EN_SETUP_CYC + EN_HIGH_CYC + EN_HOLD_CYC + EXEC_CYC (or LONG_EXEC_CYC) - 1 cycles.
- Back-to-back writes: a held request is re-granted after exactly one IDLE cycle.
- Requester contract: rs/data must be stable while req is high and until gnt. Inputs are sampled only at the grant edge; changes after that have no effect. A requester drops req in the gnt cycle if it has no more bytes.
- RS/DATA hold the last captured value until the next grant; they do not return to 0 after a write.
- Simultaneous grant edge for one requester and done for the other cannot occur (single owner at a time).
- Reset asserted mid-operation: EN falls immediately (asynchronously), no done is issued for the aborted byte, and the power-on wait restarts in full.
- A request arriving in any non-IDLE state waits; no queueing beyond the req level.

Test Plan:
(Simulation parameters for all scenarios: POR_CYC=10, EN_SETUP_CYC=2, EN_HIGH_CYC=4, EN_HOLD_CYC=2, EXEC_CYC=8, LONG_EXEC_CYC=20.)
1. Power-on: req0=1 from reset release -> busy=1 and no gnt0 for 10 cycles; gnt0 is a single one-cycle pulse on cycle 12 after release; EN=0 throughout INIT_WAIT.
2. Data write: req0 with rs0=1, data0=0x41 -> RS=1 and DATA=0x41 from the gnt0 cycle; EN rises 2 cycles after gnt0 and stays high exactly 4 cycles; done0 pulses 15 cycles after gnt0; DATA stays 0x41 afterwards.
3. Long commands: rs1=0, data1=0x01 -> gnt1 to done1 spacing is 27 cycles. Repeat with 0x02 -> 27 cycles. Repeat with 0x80, and with rs1=1 data1=0x01 -> 15 cycles.
4. Contention: req0 and req1 both held high after POR -> grant order 0,1,0,1; each done goes only to the owner; never two gnt pulses within 16 cycles.
5. Reset during PULSE (EN=1): reset_n low mid-cycle -> EN=0 before the next clk edge; no done0; after release, the 10-cycle POR wait repeats before any grant.
6. Single requester streaming: req1 held high with 3 bytes (0x30, 0x31, 0x32 presented after each gnt1) -> three writes with exactly one busy=0 cycle between done1 and the next gnt1; DATA sequence on the EN pulses is 0x30, 0x31, 0x32.

Source files
------------

// File: rtl/lcd_write_sched.sv
// LCD bus write scheduler: power-on wait, round-robin arbitration between two
// byte requesters, then RS/DATA setup, timed EN strobe, hold and execution wait.
module lcd_write_sched #(
  parameter int unsigned POR_CYC       = 750000,
  parameter int unsigned EN_SETUP_CYC  = 2,
  parameter int unsigned EN_HIGH_CYC   = 25,
  parameter int unsigned EN_HOLD_CYC   = 2,
  parameter int unsigned EXEC_CYC      = 2500,
  parameter int unsigned LONG_EXEC_CYC = 82000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       gnt0,
  output logic       done0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       gnt1,
  output logic       done1,
  output logic       busy,
  output logic       RS,
  output logic       EN,
  output logic [7:0] DATA
);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  localparam logic [CNT_W-1:0] POR_LD   = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(EN_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(EN_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             pick1;
  logic             timer_zero;
  logic             long_cmd;

  assign timer_zero = (timer_q == '0);
  // Clear display / return home need the long execution wait.
  assign long_cmd   = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rs_d    = rs_q;
    data_d  = data_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    pick1   = 1'b0;

    case (state_q)
      S_INIT_WAIT: begin
        if (timer_zero) state_d = S_IDLE;
        else            timer_d = timer_q - CNT_W'(1);
      end
      S_IDLE: begin
        if (req0 || req1) begin
          // ptr_q=1 favours requester 1 when both are requesting.
          pick1   = req1 && (!req0 || ptr_q);
          owner_d = pick1;
          ptr_d   = !pick1;
          rs_d    = pick1 ? rs1 : rs0;
          data_d  = pick1 ? data1 : data0;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          timer_d = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (timer_zero) begin
          state_d = S_PULSE;
          timer_d = HIGH_LD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (timer_zero) begin
          state_d = S_HOLD;
          timer_d = HOLD_LD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (timer_zero) begin
          state_d = S_EXEC;
          timer_d = long_cmd ? LONG_LD : EXEC_LD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (timer_zero) state_d = S_IDLE;
        else            timer_d = timer_q - CNT_W'(1);
      end
      default: begin
        state_d = S_INIT_WAIT;
        timer_d = POR_LD;
      end
    endcase

    en_d   = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE);
    // done is registered, so raise it on entry to the final EXEC cycle.
    done0_d = (state_d == S_EXEC) && (timer_d == '0) && !owner_q;
    done1_d = (state_d == S_EXEC) && (timer_d == '0) && owner_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT_WAIT;
      timer_q <= POR_LD;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;
  assign RS    = rs_q;
  assign EN    = en_q;
  assign DATA  = data_q;

endmodule

// File: tb/tb_lcd_write_sched.sv
// Bench for lcd_write_sched: directed scenarios plus random traffic, checked
// every cycle against a transaction-level timing model of the scheduler.
module tb_lcd_write_sched;

  localparam int POR  = 10;
  localparam int SU   = 2;
  localparam int HI   = 4;
  localparam int HO   = 2;
  localparam int EXE  = 8;
  localparam int LONG = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       gnt0, done0, gnt1, done1, busy, RS, EN;
  logic [7:0] DATA;

  lcd_write_sched #(
    .POR_CYC(POR), .EN_SETUP_CYC(SU), .EN_HIGH_CYC(HI), .EN_HOLD_CYC(HO),
    .EXEC_CYC(EXE), .LONG_EXEC_CYC(LONG), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .rs0(rs0), .data0(data0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .rs1(rs1), .data1(data1), .gnt1(gnt1), .done1(done1),
    .busy(busy), .RS(RS), .EN(EN), .DATA(DATA)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pending bytes per requester: {rs, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  // Reference model: write = grant cycle + fixed phase lengths
  int   cyc = 0;
  int   rel_cyc = 0;
  int   m_por = POR;
  bit   m_act = 0;
  int   m_start = 0;
  int   m_total = 0;
  bit   m_own = 0;
  bit   m_ptr = 0;
  bit   m_rs = 0;
  bit [7:0] m_data = '0;
  bit   e_en = 0;

  // Observation of DUT behaviour for directed checks
  int   first_gnt0 = -1;
  int   g0_cyc = 0, g1_cyc = 0, lat0 = -1, lat1 = -1;
  int   last_gnt_cyc = -1000, min_gap = 1000;
  int   idle_run = 0;
  bit   gnt_log[$];
  int   idle_log[$];
  logic [7:0] en_data[$];
  logic en_prev = 1'b0;

  task automatic drive();
    req0 = (q0.size() > 0);
    if (q0.size() > 0) {rs0, data0} = q0[0];
    req1 = (q1.size() > 0);
    if (q1.size() > 0) {rs1, data1} = q1[0];
  endtask

  task automatic step();
    bit r0, r1, s_rs0, s_rs1, eg0, eg1, ed0, ed1;
    bit [7:0] s_d0, s_d1;
    int off;
    r0 = req0; r1 = req1; s_rs0 = rs0; s_rs1 = rs1; s_d0 = data0; s_d1 = data1;
    @(posedge clk);
    cyc++;
    rel_cyc++;
    if (m_por > 0) m_por--;
    else if (m_act) begin
      if (cyc - m_start == m_total) m_act = 0;
    end else if (r0 || r1) begin
      m_own   = r1 && (!r0 || m_ptr);
      m_ptr   = !m_own;
      m_rs    = m_own ? s_rs1 : s_rs0;
      m_data  = m_own ? s_d1 : s_d0;
      m_total = SU + HI + HO + ((!m_rs && m_data >= 1 && m_data <= 3) ? LONG : EXE);
      m_act   = 1;
      m_start = cyc;
    end
    off  = cyc - m_start;
    eg0  = m_act && off == 0 && !m_own;
    eg1  = m_act && off == 0 && m_own;
    ed0  = m_act && off == m_total - 1 && !m_own;
    ed1  = m_act && off == m_total - 1 && m_own;
    e_en = m_act && off >= SU && off < SU + HI;
    #1;
    check("pins", {17'd0, gnt0, gnt1, done0, done1, busy, EN, RS, DATA},
          {17'd0, eg0, eg1, ed0, ed1, (m_por > 0) || m_act, e_en, m_rs, m_data});

    if (gnt0 && first_gnt0 < 0) first_gnt0 = rel_cyc;
    if (gnt0 || gnt1) begin
      if (cyc - last_gnt_cyc < min_gap) min_gap = cyc - last_gnt_cyc;
      last_gnt_cyc = cyc;
      gnt_log.push_back(gnt1);
      idle_log.push_back(idle_run);
    end
    if (!busy) idle_run++;
    if (done0 || done1) idle_run = 0;
    if (gnt0) g0_cyc = cyc;
    if (gnt1) g1_cyc = cyc;
    if (done0) lat0 = cyc - g0_cyc;
    if (done1) lat1 = cyc - g1_cyc;
    if (EN && !en_prev) en_data.push_back(DATA);
    en_prev = EN;

    if (eg0 && q0.size() > 0) void'(q0.pop_front());
    if (eg1 && q1.size() > 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int  n;
    bit  quiet;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_act || m_por > 0) && n < max_cyc) begin
      step();
      n++;
    end
    quiet = !(q0.size() > 0 || q1.size() > 0 || m_act || m_por > 0);
    check(tag, {31'd0, quiet}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_en_async", {31'd0, EN}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    m_por = POR; m_act = 0; m_ptr = 0; m_rs = 0; m_data = '0; e_en = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pins", {17'd0, gnt0, gnt1, done0, done1, busy, EN, RS, DATA}, 32'h0000_0400);
    @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = 1;
    first_gnt0 = -1;
    en_prev = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Power-on, then data write 0x41 from requester 0
    q0.push_back({1'b1, 8'h41});
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pins", {17'd0, gnt0, gnt1, done0, done1, busy, EN, RS, DATA}, 32'h0000_0400);
    @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = 1;
    drain("drain_por", 100);
    check("por_gnt0_cycle", first_gnt0, 12);
    check("lat_data", lat0, 15);
    repeat (3) step();
    check("data_hold", {24'd0, DATA}, 32'h41);

    // Long vs normal execution times on requester 1
    q1.push_back({1'b0, 8'h01}); drive(); drain("drain_c01", 100);
    check("lat_cmd01", lat1, 27);
    q1.push_back({1'b0, 8'h02}); drive(); drain("drain_c02", 100);
    check("lat_cmd02", lat1, 27);
    q1.push_back({1'b0, 8'h80}); drive(); drain("drain_c80", 100);
    check("lat_cmd80", lat1, 15);
    q1.push_back({1'b1, 8'h01}); drive(); drain("drain_d01", 100);
    check("lat_data01", lat1, 15);

    // Contention: both held, expect 0,1,0,1
    gnt_log.delete();
    min_gap = 1000;
    last_gnt_cyc = -1000;
    q0.push_back({1'b1, 8'h10}); q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h20}); q1.push_back({1'b1, 8'h21});
    drive();
    drain("drain_cont", 200);
    check("cont_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check($sformatf("cont_order%0d", i), {31'd0, gnt_log[i]}, i % 2);
    check("cont_min_gap", min_gap, 17);

    // Reset while EN is high; the second byte stays requested through reset
    q0.push_back({1'b1, 8'h55}); q0.push_back({1'b0, 8'h01});
    drive();
    n = 0;
    while (!e_en && n < 40) begin step(); n++; end
    check("reach_pulse", {31'd0, e_en}, 32'd1);
    step();
    do_reset();
    drain("drain_rst", 100);
    check("por_gnt0_after_rst", first_gnt0, 12);
    check("lat_after_rst", lat0, 27);

    // Streaming three bytes from requester 1
    idle_log.delete();
    en_data.delete();
    q1.push_back({1'b1, 8'h30}); q1.push_back({1'b1, 8'h31}); q1.push_back({1'b1, 8'h32});
    drive();
    drain("drain_stream", 200);
    check("stream_writes", en_data.size(), 3);
    for (int i = 0; i < 3 && i < en_data.size(); i++)
      check($sformatf("stream_data%0d", i), {24'd0, en_data[i]}, 32'h30 + i);
    for (int i = 1; i < 3 && i < idle_log.size(); i++)
      check($sformatf("stream_idle%0d", i), idle_log[i], 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        logic [8:0] b;
        b[8]   = 1'($urandom_range(1));
        b[7:0] = ($urandom_range(1) == 0) ? 8'($urandom_range(3, 1)) : 8'($urandom_range(255));
        if ($urandom_range(1) == 0) begin
          if (q0.size() < 3) q0.push_back(b);
        end else begin
          if (q1.size() < 3) q1.push_back(b);
        end
        drive();
      end
      step();
    end
    drain("drain_random", 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
